// File: rtl/param_registers_bank.sv
// General-purpose register file: two combinational read ports, one write port, optional
// hardwired-zero entry 0, write-to-read bypass and a clear sweep that zeroes every entry.
module param_registers_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] regA,
    input  logic [ADDR_WIDTH-1:0] regB,
    input  logic [ADDR_WIDTH-1:0] regC,
    input  logic [DATA_WIDTH-1:0] dataWrite,
    input  logic                  writeFlag,
    input  logic                  clearFlag,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    output logic                  ready,
    output logic                  writeDropped
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  zero_target;
    logic                  write_ok;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign zero_target = ZERO_REG && (regC == '0);
    // A write that really lands this edge; also the qualifier for bypass.
    assign write_ok    = reset && writeFlag && !zero_target && (state_q == StRun);

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        dropped_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = regC;
        mem_wdata   = dataWrite;
        unique case (state_q)
            StClear: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_ptr_q;
                mem_wdata   = '0;
                clear_ptr_d = clear_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (&clear_ptr_q) begin
                    state_d = StRun;
                end
                dropped_d = writeFlag && !zero_target;
            end
            StRun: begin
                mem_we = write_ok;
                if (clearFlag) begin
                    state_d     = StClear;
                    clear_ptr_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StClear;
            clear_ptr_q <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            dropped_q   <= dropped_d;
        end
    end

    // Storage has no reset; contents are defined by the sweep, and held while reset is low.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready        = (state_q == StRun);
    assign writeDropped = dropped_q;

    always_comb begin
        dataA = '0;
        if (ready) begin
            if (BYPASS && write_ok && (regC == regA)) begin
                dataA = dataWrite;
            end else begin
                dataA = mem_q[regA];
            end
            if (ZERO_REG && (regA == '0)) begin
                dataA = '0;
            end
        end
    end

    always_comb begin
        dataB = '0;
        if (ready) begin
            if (BYPASS && write_ok && (regC == regB)) begin
                dataB = dataWrite;
            end else begin
                dataB = mem_q[regB];
            end
            if (ZERO_REG && (regB == '0)) begin
                dataB = '0;
            end
        end
    end

endmodule

// File: doc/param_registers_bank.md
# param_registers_bank

Parametrised general-purpose register file for the CoreBassier datapath: two asynchronous read ports, one synchronous write port, and an optional hardwired-zero register 0. It adds three things the fixed 32x32 bank lacks: a write-to-read bypass, a hardware clear sequencer that zeroes every entry after reset or on request, and a `ready` flag. It sits between decode (read addresses), writeback (write port) and the ALU operand inputs.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2^ADDR_WIDTH entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- regA  in  ADDR_WIDTH  read address, port A
- regB  in  ADDR_WIDTH  read address, port B
- regC  in  ADDR_WIDTH  write address
- dataWrite  in  DATA_WIDTH  write data
- writeFlag  in  1  write enable
- clearFlag  in  1  request to start a full clear sweep
- dataA  out  DATA_WIDTH  read data, port A (combinational)
- dataB  out  DATA_WIDTH  read data, port B (combinational)
- ready  out  1  1 = bank is in RUN and holds valid contents
- writeDropped  out  1  one-cycle pulse: the previous cycle's write was discarded

The block uses one clock. Reset is synchronous and active-low.

## Operation
- FSM states: CLEAR and RUN. A 2-state encoding is sufficient. The state and the ADDR_WIDTH-bit clearPtr are the only control state.
- Reset low at an edge: state <= CLEAR, clearPtr <= 0, writeDropped <= 0. No entry is written while reset is low.
- CLEAR, reset high: each edge writes 0 to entry clearPtr and increments clearPtr.
  - On the edge that clears entry DEPTH-1, the FSM moves to RUN and clearPtr wraps to 0.
  - A full sweep is exactly DEPTH edges.
- CLEAR with writeFlag=1: the write is discarded and writeDropped=1 after that edge.
  - Exception: when ZERO_REG=1 and regC=0, the write is discarded silently (no writeDropped pulse).
- CLEAR with clearFlag=1: ignored. The sweep does not restart.
- RUN with writeFlag=1: entry regC <= dataWrite. When ZERO_REG=1, a write to entry 0 is discarded without a writeDropped pulse.
- RUN with clearFlag=1: the FSM moves to CLEAR on that edge and clearPtr <= 0. A write in the same cycle is performed first and is then overwritten by the sweep.
- Reads:
  - When ready=0, dataA and dataB are forced to 0.
  - When ready=1, each port returns entry regX.
  - When ZERO_REG=1 and regX=0, the port returns 0.
- Bypass (BYPASS=1, ready=1, writeFlag=1, regC==regX, and the write is not discarded): dataX = dataWrite in the same cycle. Both ports may bypass simultaneously.
- With BYPASS=0, a write is visible on the read ports only after the write edge.
- Reset values: ready=0, writeDropped=0, dataA=dataB=0. Entry contents are undefined until the first sweep completes.

## Timing
- Read latency is 0 cycles (combinational from regA, regB, state, registers and, with bypass, the write-port inputs).
- Write latency is 1 edge. Read-after-write to the same address is 0 cycles with bypass and 1 cycle without.
- ready rises after the DEPTH-th rising edge with reset high that follows a reset. With ADDR_WIDTH=5, that is 32 edges.
- ready falls after the edge that samples clearFlag=1 in RUN, and rises again DEPTH edges later.
- writeDropped is registered: high for exactly one cycle after each discarded write.
- Reset low mid-sweep: the sweep restarts from entry 0 on the first edge after reset is released.
- Reset low during RUN: the FSM enters CLEAR. Contents are kept while reset is held low, and all entries are re-zeroed once reset is released.

## Test plan
- Reset sweep (ADDR_WIDTH=5): hold reset low for 3 edges, then release -> ready=0 for the next 31 edges and ready=1 after the 32nd. All 32 entries read 0.
- Write/read with bypass: write 0xDEADBEEF to entry 7 with regA=7 in the same cycle -> dataA=0xDEADBEEF in that cycle. With BYPASS=0, dataA=0 in that cycle and 0xDEADBEEF after the edge.
- Zero register (ZERO_REG=1): write 0x12345678 to entry 0 -> dataA=0 with regA=0, no bypass, and writeDropped stays 0. Repeat with ZERO_REG=0 -> dataA=0x12345678 after the edge.
- Clear request: fill entries 1..31 with their index, assert clearFlag for 1 cycle together with a write of 0xAA to entry 5 -> ready=0 next cycle and for 32 edges total. Afterwards all entries read 0, including entry 5.
- Write during sweep: writeFlag=1 to entry 3 at sweep step 10 -> writeDropped=1 for exactly 1 cycle. After ready=1, entry 3 reads 0. A clearFlag at step 12 does not extend the sweep (ready still rises at edge 32).
- Reset mid-sweep: assert reset at sweep step 20 for 1 edge -> ready rises 32 edges after reset is released, not 12.
